// File: rtl/prime_pkg.sv
// Shared types and defaults for the trial-division prime checker.
package prime_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        MOD  = 2'd2,
        DONE = 2'd3
    } prime_state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/prime_checker_if.sv
// Request/result link between the user-entry front end and the prime checker.
interface prime_checker_if #(
    parameter int WIDTH = prime_pkg::DEFAULT_WIDTH
);
    logic             en_i;
    logic [WIDTH-1:0] data_i;
    logic             busy_o;
    logic             valid_o;
    logic             prime_o;
    logic [WIDTH-1:0] data_o;

    modport master (
        output en_i,
        output data_i,
        input  busy_o,
        input  valid_o,
        input  prime_o,
        input  data_o
    );

    modport slave (
        input  en_i,
        input  data_i,
        output busy_o,
        output valid_o,
        output prime_o,
        output data_o
    );
endinterface

// File: rtl/prime_checker.sv
// Trial-division primality test; remainders come from repeated subtraction,
// so the datapath needs only a comparator, a subtractor and a small squarer.
module prime_checker
    import prime_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    prime_checker_if.slave  bus
);

    prime_state_t           state;
    prime_state_t           state_next;
    logic [WIDTH-1:0]       n;
    logic [WIDTH-1:0]       d;
    logic [WIDTH-1:0]       r;
    logic                   busy;
    logic                   valid;
    logic                   prime;
    logic [WIDTH-1:0]       data_result;

    logic [2*WIDTH-1:0]     d_sq;
    logic [2*WIDTH-1:0]     n_wide;
    logic                   finish;
    logic                   finish_prime;

    // Squaring in double width keeps d*d from wrapping when d reaches ceil(sqrt(2**WIDTH)).
    assign d_sq   = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
    assign n_wide = {{WIDTH{1'b0}}, n};

    always_comb begin
        state_next   = state;
        finish       = 1'b0;
        finish_prime = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en_i) begin
                    state_next = TEST;
                end
            end
            TEST: begin
                if (n < WIDTH'(2)) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end else if (d_sq > n_wide) begin
                    state_next   = DONE;
                    finish       = 1'b1;
                    finish_prime = 1'b1;
                end else begin
                    state_next = MOD;
                end
            end
            MOD: begin
                if (r >= d) begin
                    state_next = MOD;
                end else if (r == '0) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end else begin
                    state_next = TEST;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers load on the transition into DONE, so valid coincides with DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n           <= '0;
            d           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            prime       <= 1'b0;
            data_result <= '0;
        end else begin
            state <= state_next;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en_i) begin
                        n    <= bus.data_i;
                        d    <= WIDTH'(2);
                        busy <= 1'b1;
                    end
                end
                TEST: begin
                    if (state_next == MOD) begin
                        r <= n;
                    end
                end
                MOD: begin
                    if (r >= d) begin
                        r <= r - d;
                    end else if (r != '0) begin
                        d <= d + WIDTH'(1);
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
            if (finish) begin
                valid       <= 1'b1;
                prime       <= finish_prime;
                data_result <= n;
            end
        end
    end

    assign bus.busy_o  = busy;
    assign bus.valid_o = valid;
    assign bus.prime_o = prime;
    assign bus.data_o  = data_result;

endmodule
